ww_mlp_regressor: RTL and testbench

- Fixed-weight, 2-stage pipelined multilayer-perceptron regressor for the white-wine quality model.
- Takes 11 unsigned 4-bit features and produces one unsigned 21-bit score.
- Topology: 11 inputs -> 3 hidden ReLU neurons -> 1 linear output.
- All weights and biases are hard-wired constants.
- Sits as the top of the classifier datapath; fed directly by a feature source.

---
 rtl/ww_mlp_pkg.sv | 32 +++
 rtl/ww_mlp_neuron.sv | 33 +++
 rtl/ww_mlp_regressor.sv | 77 +++++++
 tb/tb_ww_mlp_regressor.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/ww_mlp_pkg.sv
// Fixed weights, biases and datapath widths for the white-wine quality MLP regressor.
// Every constant here is hard-wired; nothing is programmable at run time.
package ww_mlp_pkg;

    localparam int NUM_A    = 11;
    localparam int WIDTH_A  = 4;
    localparam int OUTWIDTH = 21;
    localparam int NUM_H    = 3;

    // Hidden activation width, hidden accumulator width, output accumulator width
    localparam int RW   = 15;
    localparam int ACCW = 18;
    localparam int YW   = 26;

    typedef logic signed [7:0] weight_t;

    localparam weight_t W1 [NUM_H][NUM_A] = '{
        '{8'sd3, -8'sd2, 8'sd1, 8'sd0, 8'sd4, -8'sd1, 8'sd2, 8'sd0, -8'sd3, 8'sd5, 8'sd1},
        '{-8'sd4, 8'sd1, 8'sd0, 8'sd2, -8'sd1, 8'sd3, 8'sd0, 8'sd1, 8'sd2, -8'sd2, 8'sd6},
        '{8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127,
          8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127}
    };

    localparam weight_t B1 [NUM_H] = '{8'sd10, -8'sd20, 8'sd0};
    localparam weight_t W2 [NUM_H] = '{8'sd2, 8'sd3, 8'sd127};
    localparam weight_t BO         = 8'sd5;

    // Largest value representable on the unsigned score / hidden outputs
    localparam logic signed [YW-1:0]   SAT_MAX = 26'sd2097151;
    localparam logic signed [ACCW-1:0] R_MAX   = 18'sd32767;

endpackage

// File: rtl/ww_mlp_neuron.sv
// Purpose: combinational dot product of the feature vector with hidden row H, plus bias, optional ReLU.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the input every cycle.
module ww_mlp_neuron
    import ww_mlp_pkg::*;
#(
    parameter int H    = 0,
    parameter bit RELU = 1'b1
) (
    input  logic [NUM_A*WIDTH_A-1:0] feat,
    output logic [RW-1:0]            r
);

    logic signed [ACCW-1:0] acc;

    always_comb begin
        acc = ACCW'(B1[H]);
        // Features are unsigned: zero-extend before treating them as signed operands
        for (int i = 0; i < NUM_A; i++) begin
            acc = acc + ACCW'(W1[H][i]) * $signed(ACCW'(feat[i*WIDTH_A +: WIDTH_A]));
        end
    end

    always_comb begin
        r = acc[RW-1:0];
        if (RELU && (acc < 0)) begin
            r = '0;
        end else if (acc > R_MAX) begin
            r = '1;
        end
    end

endmodule

// File: rtl/ww_mlp_regressor.sv
// Purpose: fixed-weight 11-3-1 MLP regressor (ReLU hidden layer, saturating linear output).
// Latency: 2 cycles, one vector per clock.
// Backpressure: none; in_valid may be asserted every cycle, bubbles propagate as out_valid=0.
module ww_mlp_regressor
    import ww_mlp_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [NUM_A*WIDTH_A-1:0] inp,
    output logic                     out_valid,
    output logic [OUTWIDTH-1:0]      out
);

    logic [RW-1:0]         h_comb [NUM_H];
    logic [RW-1:0]         h_q    [NUM_H];
    logic                  v1_q;
    logic signed [YW-1:0]  y;
    logic [OUTWIDTH-1:0]   y_sat;

    for (genvar h = 0; h < NUM_H; h++) begin : g_neuron
        ww_mlp_neuron #(
            .H    (h),
            .RELU (1'b1)
        ) u_neuron (
            .feat (inp),
            .r    (h_comb[h])
        );
    end

    // Stage 1: hidden activations; held across bubbles so no X enters the datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            for (int h = 0; h < NUM_H; h++) begin
                h_q[h] <= '0;
            end
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                for (int h = 0; h < NUM_H; h++) begin
                    h_q[h] <= h_comb[h];
                end
            end
        end
    end

    always_comb begin
        y = YW'(BO);
        for (int h = 0; h < NUM_H; h++) begin
            y = y + YW'(W2[h]) * $signed(YW'(h_q[h]));
        end
    end

    always_comb begin
        y_sat = y[OUTWIDTH-1:0];
        if (y < 0) begin
            y_sat = '0;
        end else if (y > SAT_MAX) begin
            y_sat = '1;
        end
    end

    // Stage 2: saturated score; out keeps its last value while out_valid is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            out_valid <= v1_q;
            if (v1_q) begin
                out <= y_sat;
            end
        end
    end

endmodule

// File: tb/tb_ww_mlp_regressor.sv
// Directed bench for ww_mlp_regressor: table of hand-computed single vectors plus
// back-to-back and mid-stream asynchronous reset sequences.
module tb_ww_mlp_regressor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [43:0] inp;
    logic        out_valid;
    logic [20:0] out;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       name;
        logic [43:0] inp;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    ww_mlp_regressor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inp       (inp),
        .out_valid (out_valid),
        .out       (out)
    );

    function automatic logic [43:0] one_feat(int idx, logic [3:0] val);
        logic [43:0] v;
        v = '0;
        v[idx*4 +: 4] = val;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    logic [43:0] all15;
    logic [20:0] b2b_exp [3];

    initial begin
        all15 = '1;
        vecs[0] = '{name: "zeros",     inp: 44'd0,            exp: 21'd25};
        vecs[1] = '{name: "f0_eq_1",   inp: one_feat(0, 4'd1),  exp: 21'd16160};
        vecs[2] = '{name: "f10_eq_15", inp: one_feat(10, 4'd15), exp: 21'd242200};
        vecs[3] = '{name: "all_15",    inp: all15,            exp: 21'd2097151};
        vecs[4] = '{name: "f4_eq_15",  inp: one_feat(4, 4'd15),  exp: 21'd242080};
        vecs[5] = '{name: "f9_eq_15",  inp: one_feat(9, 4'd15),  exp: 21'd242110};
        vecs[6] = '{name: "f1_eq_15",  inp: one_feat(1, 4'd15),  exp: 21'd241940};
        vecs[7] = '{name: "f3_eq_15",  inp: one_feat(3, 4'd15),  exp: 21'd241990};
        b2b_exp[0] = 21'd25;
        b2b_exp[1] = 21'd16160;
        b2b_exp[2] = 21'd242200;

        // Reset held with valid traffic present: outputs must stay cleared
        rst_n    = 1'b0;
        in_valid = 1'b1;
        inp      = {12'($urandom), $urandom};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst_out", 32'(out), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            inp = {12'($urandom), $urandom};
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        inp      = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_idle_valid", 32'(out_valid), 32'd0);
        end

        // Single vectors, each followed by a bubble
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            inp      = vecs[k].inp;
            @(negedge clk);
            in_valid = 1'b0;
            inp      = '0;
            @(negedge clk);
            check({vecs[k].name, "_valid"}, 32'(out_valid), 32'd1);
            check(vecs[k].name, 32'(out), 32'(vecs[k].exp));
            @(negedge clk);
            check({vecs[k].name, "_bubble"}, 32'(out_valid), 32'd0);
        end

        // Back-to-back vectors: three consecutive results, then low
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 2 && i < 5) begin
                check("b2b_valid", 32'(out_valid), 32'd1);
                check("b2b_out", 32'(out), 32'(b2b_exp[i-2]));
            end else if (i == 5) begin
                check("b2b_tail_valid", 32'(out_valid), 32'd0);
            end
            in_valid = (i < 3);
            inp      = (i < 3) ? vecs[i].inp : 44'd0;
        end

        // Back-to-back again, with asynchronous reset between 2nd and 3rd result
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check("rst_b2b_valid", 32'(out_valid), 32'd1);
                check("rst_b2b_out", 32'(out), 32'(b2b_exp[i-2]));
            end
            in_valid = (i < 3);
            inp      = (i < 3) ? vecs[i].inp : 44'd0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(out), 32'd0);
        check("async_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("no_pulse_after_rst", 32'(out_valid), 32'd0);
            check("out_cleared_after_rst", 32'(out), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
